// File: rtl/button_event_arbiter.sv
// Debounces NBTN raw buttons, generates press and auto-repeat events per button,
// and offers them one at a time through a round-robin valid/ready arbiter.
module button_event_arbiter #(
    parameter int NBTN       = 5,
    parameter int DEB_MAX    = 1000000,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_in,
    input  logic            evt_ready,
    input  logic            clr_overrun,
    output logic            evt_valid,
    output logic [2:0]      evt_id,
    output logic            evt_repeat,
    output logic [NBTN-1:0] held,
    output logic [NBTN-1:0] overrun
);

    localparam logic [24:0] DEB_TOP  = 25'(DEB_MAX - 1);
    localparam logic [24:0] REPD_TOP = 25'(REP_DELAY - 1);
    localparam logic [24:0] REPP_TOP = 25'(REP_PERIOD - 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state;
    logic [2:0]      last_grant;
    logic [NBTN-1:0] sync_p0, sync_p1;
    logic [24:0]     deb_cnt [NBTN];
    logic [24:0]     rep_cnt [NBTN];
    logic [NBTN-1:0] rep_first;
    logic [NBTN-1:0] pending, rep_flag;

    logic [NBTN-1:0] press, release_evt, rep_fire, set_evt, accept;
    logic [NBTN-1:0] pending_nxt, rep_nxt, ovr_set;
    logic [2:0]      pick_idle, pick_next;

    function automatic logic bit_at(input logic [NBTN-1:0] v, input logic [2:0] idx);
        logic [NBTN-1:0] s;
        s = v >> idx;
        return s[0];
    endfunction

    // First set bit of mask found scanning upward from last+1, wrapping at NBTN.
    function automatic logic [2:0] rr_pick(input logic [NBTN-1:0] mask, input logic [2:0] last);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NBTN; k++) begin
            idx = (int'(last) + k) % NBTN;
            if (!found && bit_at(mask, 3'(idx))) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        press       = '0;
        release_evt = '0;
        rep_fire    = '0;
        set_evt     = '0;
        accept      = '0;
        pending_nxt = '0;
        rep_nxt     = '0;
        ovr_set     = '0;
        for (int i = 0; i < NBTN; i++) begin
            press[i]       = (sync_p1[i] != held[i]) && (deb_cnt[i] == DEB_TOP) && !held[i];
            release_evt[i] = (sync_p1[i] != held[i]) && (deb_cnt[i] == DEB_TOP) && held[i];
            // A release on the same cycle as a repeat deadline suppresses the repeat.
            rep_fire[i]    = held[i] && !release_evt[i] &&
                             (rep_cnt[i] == (rep_first[i] ? REPD_TOP : REPP_TOP));
            set_evt[i]     = press[i] | rep_fire[i];
            accept[i]      = (state == OFFER) && evt_ready && (evt_id == 3'(i));
            pending_nxt[i] = set_evt[i] | (pending[i] & ~accept[i]);
            rep_nxt[i]     = set_evt[i] ? rep_fire[i] : rep_flag[i];
            ovr_set[i]     = set_evt[i] & pending[i] & ~accept[i];
        end
        pick_idle = rr_pick(pending, last_grant);
        pick_next = rr_pick(pending_nxt, evt_id);
    end

    // Synchronizer, debounce, repeat timers and pending/overrun bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            held      <= '0;
            rep_first <= '0;
            pending   <= '0;
            rep_flag  <= '0;
            overrun   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                deb_cnt[i] <= '0;
                rep_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
            for (int i = 0; i < NBTN; i++) begin
                if (sync_p1[i] == held[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_TOP) begin
                    deb_cnt[i] <= '0;
                    held[i]    <= ~held[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 25'd1;
                end

                if (press[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end else if (release_evt[i] || !held[i]) begin
                    rep_cnt[i] <= '0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 25'd1;
                end
            end
            pending  <= pending_nxt;
            rep_flag <= rep_nxt;
            overrun  <= ovr_set | (clr_overrun ? '0 : overrun);
        end
    end

    // Arbiter: offer stays registered and stable until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 3'(NBTN - 1);
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_repeat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state      <= OFFER;
                        evt_valid  <= 1'b1;
                        evt_id     <= pick_idle;
                        evt_repeat <= bit_at(rep_flag, pick_idle);
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        last_grant <= evt_id;
                        if (|pending_nxt) begin
                            evt_id     <= pick_next;
                            evt_repeat <= bit_at(rep_nxt, pick_next);
                        end else begin
                            state     <= IDLE;
                            evt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter NBTN, default 5: number of button inputs, range 2..8.
REQ-002 Parameter DEB_MAX, default 1000000: consecutive stable cycles required to accept a level change.
REQ-003 Parameter REP_DELAY, default 25000000: cycles from accepted press to first auto-repeat event.
REQ-004 Parameter REP_PERIOD, default 5000000: cycles between subsequent auto-repeat events.
REQ-005 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port btn_in, input, NBTN: raw asynchronous button levels, 1 = pressed.
REQ-008 Port evt_ready, input, 1: consumer accepts the offered event.
REQ-009 Port clr_overrun, input, 1: synchronous clear of all overrun flags.
REQ-010 Port evt_valid, output, 1: event offered.
REQ-011 Port evt_id, output, 3: index of the offered button.
REQ-012 Port evt_repeat, output, 1: 1 = auto-repeat event, 0 = initial press.
REQ-013 Port held, output, NBTN: debounced button levels.
REQ-014 Port overrun, output, NBTN: sticky flag per button, set when an event was lost.

Function
REQ-015 Each btn_in bit SHALL pass through a 2-flop synchronizer; synchronizer latency is 2 cycles.
REQ-016 Per button: a 25-bit debounce counter SHALL clear whenever the synchronized level equals held[i], increment otherwise; held[i] SHALL toggle on the cycle the counter reaches DEB_MAX-1, and the counter SHALL clear on that cycle.
REQ-017 Any glitch back to the held level before DEB_MAX cycles SHALL clear the counter with no held change.
REQ-018 A held[i] 0->1 transition SHALL set pending[i] with rep_flag[i]=0 and clear a 25-bit repeat counter for button i.
REQ-019 While held[i]=1, the repeat counter SHALL increment; reaching REP_DELAY-1 (first) or REP_PERIOD-1 (later) SHALL set pending[i] with rep_flag[i]=1 and reload the counter to 0.
REQ-020 A held[i] 1->0 transition SHALL stop and clear the repeat counter; pending[i] is not cleared by release.
REQ-021 Setting pending[i] while already 1 (and not being accepted that cycle) SHALL set overrun[i]; rep_flag[i] takes the new value.
REQ-022 Set and accept of pending[i] in the same cycle: set wins, pending[i] stays 1, overrun[i] unchanged.
REQ-023 Arbiter FSM states IDLE and OFFER; IDLE->OFFER when any pending bit is 1; OFFER->IDLE on accept when no other pending bit remains.
REQ-024 Grant SHALL be round-robin: search starts at index (last_grant+1) mod NBTN; last_grant resets to NBTN-1 so index 0 wins first.
REQ-025 In OFFER, evt_valid=1 and evt_id, evt_repeat SHALL be registered and held stable until evt_valid && evt_ready.
REQ-026 On accept, pending[evt_id] SHALL clear, last_grant SHALL update, and if other pending bits exist the next event SHALL be offered in the following cycle (1 event per cycle max).
REQ-027 clr_overrun SHALL clear all overrun bits; a coincident overrun set wins for that bit.
REQ-028 evt_id upper bits beyond NBTN range SHALL be 0.

Reset
REQ-029 rst_n low SHALL asynchronously clear synchronizers, held, all counters, pending, rep_flag, overrun, evt_valid, evt_id, evt_repeat, and set FSM to IDLE, last_grant to NBTN-1.
REQ-030 Reset asserted mid-offer SHALL drop evt_valid immediately; no event survives reset.
REQ-031 After rst_n rises, a button already pressed SHALL produce one press event after 2+DEB_MAX cycles.

Verification (bench params DEB_MAX=4, REP_DELAY=20, REP_PERIOD=8, NBTN=5, evt_ready=1 unless noted)
REQ-032 btn_in[2] high 3 cycles then low -> held stays 0, no event; then held high -> held[2]=1 at cycle 6, one event id=2 repeat=0.
REQ-033 btn_in[1] held 60 cycles -> press event, repeat events at +20, +28, +36, +44, +52 cycles after press; release -> no further events.
REQ-034 btn_in[0],[3],[4] rise in same cycle -> events id 0,3,4 in consecutive cycles; next simultaneous burst starts at id 0 after last_grant=4.
REQ-035 evt_ready=0 while button 2 repeats twice -> evt_valid held with id=2 stable, overrun[2]=1; clr_overrun -> overrun=0.
REQ-036 rst_n pulsed low while evt_valid=1 -> evt_valid=0, pending=0, held=0 same cycle, no event until re-debounce completes.
